halt_cause_ctrl: RTL

//  Parametrised successor of the single-bit core halt flop. Arbitrates NUM_CAUSES halt sources
//  and drains the pipeline before declaring halted. Records which cause won and counts halt

---
 rtl/halt_cause_ctrl_if.sv | 46 ++++
 rtl/halt_cause_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/halt_cause_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : halt_cause_ctrl_if
// Brief    : Halt-request / resume-handshake bundle between the core side
//            (master) and the halt cause controller (slave).
//            step_req exists only when HALT_STEP_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface halt_cause_ctrl_if #(
    parameter int NUM_CAUSES = 4,
    parameter int CNT_W      = 8,
    parameter int CAUSE_W    = $clog2(NUM_CAUSES + 1)
);
    logic [NUM_CAUSES-1:0] cause_i;
    logic                  pipe_empty;
    logic                  retire;
    logic                  unhalt_req;
    logic                  unhalt_ack;
    logic                  stall;
    logic                  halted;
    logic [CAUSE_W-1:0]    halt_cause;
    logic [NUM_CAUSES-1:0] pending;
    logic [CNT_W-1:0]      halt_count;
`ifdef HALT_STEP_EN
    logic                  step_req;

    modport master (
        output cause_i, pipe_empty, retire, unhalt_req, step_req,
        input  unhalt_ack, stall, halted, halt_cause, pending, halt_count
    );
    modport slave (
        input  cause_i, pipe_empty, retire, unhalt_req, step_req,
        output unhalt_ack, stall, halted, halt_cause, pending, halt_count
    );
`else
    modport master (
        output cause_i, pipe_empty, retire, unhalt_req,
        input  unhalt_ack, stall, halted, halt_cause, pending, halt_count
    );
    modport slave (
        input  cause_i, pipe_empty, retire, unhalt_req,
        output unhalt_ack, stall, halted, halt_cause, pending, halt_count
    );
`endif
endinterface
`default_nettype wire

// File: rtl/halt_cause_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : halt_cause_ctrl
// Brief    : Prioritised halt-cause arbiter with pipeline drain, sticky pending
//            causes, saturating halt-event counter and req/ack resume.
//            Optional single-step support under macro HALT_STEP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module halt_cause_ctrl #(
    parameter int NUM_CAUSES = 4,
    parameter int CAUSE_W    = $clog2(NUM_CAUSES + 1),
    parameter int CNT_W      = 8
) (
    input  wire logic        clk,
    input  wire logic        reset,
    halt_cause_ctrl_if.slave bus
);

`ifdef HALT_STEP_EN
    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_HALTING = 3'd1,
        ST_HALTED  = 3'd2,
        ST_RESUME  = 3'd3,
        ST_STEP    = 3'd4
    } state_t;

    localparam logic [CAUSE_W-1:0] c_step_code = CAUSE_W'(NUM_CAUSES);
`else
    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_HALTING = 3'd1,
        ST_HALTED  = 3'd2,
        ST_RESUME  = 3'd3
    } state_t;
`endif

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CAUSE_W-1:0]    r_halt_cause;
    logic [NUM_CAUSES-1:0] r_pending;
    logic [CNT_W-1:0]      r_halt_count;

    logic                  w_any_cause;
    logic [CAUSE_W-1:0]    w_cause_enc;
    logic                  w_halt_entry;
    logic                  w_step_done;
    logic                  w_clear_pending;
    logic                  w_stall;
    logic                  w_halted;
    logic                  w_unhalt_ack;

    // Lowest set index wins: scan from the top so lower indices overwrite.
    always_comb begin
        w_any_cause = |bus.cause_i;
        w_cause_enc = '0;
        for (int i = NUM_CAUSES - 1; i >= 0; i--) begin
            if (bus.cause_i[i]) begin
                w_cause_enc = CAUSE_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_halt_entry    = 1'b0;
        w_step_done     = 1'b0;
        w_clear_pending = 1'b0;
        w_stall         = 1'b0;
        w_halted        = 1'b0;
        w_unhalt_ack    = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_any_cause) begin
                    w_state_nxt  = ST_HALTING;
                    w_halt_entry = 1'b1;
                end
            end

            ST_HALTING: begin
                w_stall = 1'b1;
                if (bus.pipe_empty) begin
                    w_state_nxt = ST_HALTED;
                end
            end

            ST_HALTED: begin
                w_stall  = 1'b1;
                w_halted = 1'b1;
                if (bus.unhalt_req) begin
                    w_state_nxt = ST_RESUME;
                end
`ifdef HALT_STEP_EN
                else if (bus.step_req) begin
                    w_state_nxt = ST_STEP;
                end
`endif
            end

            ST_RESUME: begin
                w_unhalt_ack    = 1'b1;
                w_clear_pending = 1'b1;
                w_state_nxt     = ST_RUN;
            end

`ifdef HALT_STEP_EN
            // A genuine cause outranks the step completion and is counted.
            ST_STEP: begin
                if (w_any_cause) begin
                    w_state_nxt  = ST_HALTING;
                    w_halt_entry = 1'b1;
                end else if (bus.retire) begin
                    w_state_nxt = ST_HALTING;
                    w_step_done = 1'b1;
                end
            end
`endif

            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_halt_cause <= '0;
            r_halt_count <= '0;
        end else if (w_halt_entry) begin
            r_halt_cause <= w_cause_enc;
            if (r_halt_count != c_cnt_max) begin
                r_halt_count <= r_halt_count + CNT_W'(1);
            end
        end
`ifdef HALT_STEP_EN
        else if (w_step_done) begin
            r_halt_cause <= c_step_code;
        end
`endif
    end

    // Causes accumulate in every state; the resume cycle wipes the record.
    always_ff @(posedge clk) begin
        if (reset || w_clear_pending) begin
            r_pending <= '0;
        end else begin
            r_pending <= r_pending | bus.cause_i;
        end
    end

`ifndef HALT_STEP_EN
    logic w_unused_retire;
    assign w_unused_retire = bus.retire | w_step_done;
`endif

    assign bus.stall      = w_stall;
    assign bus.halted     = w_halted;
    assign bus.unhalt_ack = w_unhalt_ack;
    assign bus.halt_cause = r_halt_cause;
    assign bus.pending    = r_pending;
    assign bus.halt_count = r_halt_count;

endmodule
`default_nettype wire
